// File: rtl/regfile_mp_if.sv
// regfile_mp_if: ID/WB-side bundle for the multi-read-port register file.
// The master side drives writes, allocations and reads; the slave side is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     init_req;
    logic                     ready;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W/8-1:0]      wbe;
    logic                     alloc;
    logic [ADDR_W-1:0]        alloc_addr;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rvalid;

    modport master (
        output init_req, we, waddr, wdata, wbe, alloc, alloc_addr, re, raddr,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  init_req, we, waddr, wdata, wbe, alloc, alloc_addr, re, raddr,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parameterised GPR file with NUM_RD read ports, byte-enabled writes, pending scoreboard
// and a hardware clear sequencer. Define REGFILE_BYPASS_EN to forward same-cycle writes to readers.

module regfile_mp_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_ready,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_pend,
    input  logic              i_byp_hit,
    input  logic [DATA_W-1:0] i_byp_word,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);
    always_comb begin
        o_rdata  = '0;
        o_rvalid = 1'b0;
        if (i_ready && i_re) begin
            if (i_raddr == '0) begin
                o_rvalid = 1'b1;
            end else if (i_byp_hit) begin
                o_rdata  = i_byp_word;
                o_rvalid = 1'b1;
            end else begin
                o_rdata  = i_word;
                o_rvalid = !i_pend;
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [ADDR_W-1:0]             r_ptr, w_ptr_nxt;
    logic [DEPTH-1:1]              r_pending, w_pending_nxt;
    logic                          r_ready, w_ready_nxt;
    logic [DATA_W-1:0]             r_regs [DEPTH];

    logic                          w_run;
    logic                          w_wr_en;
    logic                          w_alloc_en;
    logic [DEPTH-1:0]              w_pend_vec;
    logic [NUM_RD-1:0][ADDR_W-1:0] w_raddr;
    logic [NUM_RD-1:0][DATA_W-1:0] w_rdata;
    logic [NUM_RD-1:0]             w_rvalid;

    // A RUN-state init_req pre-empts any write or allocation in the same cycle.
    assign w_run      = (r_state == ST_RUN) && !bus.init_req;
    assign w_wr_en    = w_run && bus.we && (bus.waddr != '0);
    assign w_alloc_en = w_run && bus.alloc && (bus.alloc_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_ptr     <= FIRST_ADDR;
            r_pending <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_pending <= w_pending_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_pending_nxt = r_pending;
        w_ready_nxt   = r_ready;
        case (r_state)
            ST_INIT: begin
                w_ptr_nxt     = r_ptr + 1'b1;
                w_pending_nxt = '0;
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.init_req) begin
                    w_state_nxt   = ST_INIT;
                    w_ptr_nxt     = FIRST_ADDR;
                    w_ready_nxt   = 1'b0;
                    w_pending_nxt = '0;
                end else begin
                    // Allocation is applied after the write so it wins on a same-address collision.
                    for (int i = 1; i < DEPTH; i++) begin
                        if (w_wr_en && (bus.waddr == ADDR_W'(i)))
                            w_pending_nxt[i] = 1'b0;
                        if (w_alloc_en && (bus.alloc_addr == ADDR_W'(i)))
                            w_pending_nxt[i] = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Storage is not reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_regs[r_ptr] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wbe[b])
                    r_regs[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign w_pend_vec = {r_pending, 1'b0};
    assign w_raddr    = bus.raddr;
    assign bus.rdata  = w_rdata;
    assign bus.rvalid = w_rvalid;
    assign bus.ready  = r_ready;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_W-1:0] w_word;
        logic [DATA_W-1:0] w_byp_word;
        logic              w_byp_hit;

        assign w_word = r_regs[w_raddr[p]];

`ifdef REGFILE_BYPASS_EN
        assign w_byp_hit = (r_state == ST_RUN) && bus.we &&
                           (bus.waddr == w_raddr[p]) && (w_raddr[p] != '0);

        always_comb begin
            w_byp_word = w_word;
            for (int b = 0; b < NB; b++) begin
                if (bus.wbe[b])
                    w_byp_word[8*b +: 8] = bus.wdata[8*b +: 8];
            end
        end
`else
        assign w_byp_hit  = 1'b0;
        assign w_byp_word = w_word;
`endif

        regfile_mp_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .i_ready    (r_ready),
            .i_re       (bus.re[p]),
            .i_raddr    (w_raddr[p]),
            .i_word     (w_word),
            .i_pend     (w_pend_vec[w_raddr[p]]),
            .i_byp_hit  (w_byp_hit),
            .i_byp_word (w_byp_word),
            .o_rdata    (w_rdata[p]),
            .o_rvalid   (w_rvalid[p])
        );
    end
endmodule
